// File: rtl/pwl_sequencer_if.sv
// Handshake, configuration and status bundle for pwl_sequencer.
// master = the agent driving x/config and consuming results; slave = the sequencer.
interface pwl_sequencer_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic         cfg_we;
  logic [1:0]   cfg_sel;
  logic [3:0]   cfg_addr;
  logic [W-1:0] cfg_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic [3:0]   out_seg;
  logic         busy;
  logic         cfg_err;

  modport master (
    output in_valid, in_x, cfg_we, cfg_sel, cfg_addr, cfg_data, out_ready,
    input  in_ready, out_valid, out_y, out_seg, busy, cfg_err
  );

  modport slave (
    input  in_valid, in_x, cfg_we, cfg_sel, cfg_addr, cfg_data, out_ready,
    output in_ready, out_valid, out_y, out_seg, busy, cfg_err
  );
endinterface

// File: rtl/pwl_sequencer.sv
// Piecewise-linear evaluator: linear segment search over a 16-entry bound table, then y = slope*x + intercept.
// Define PWL_SAT_EN to clamp the result to the signed W-bit range; otherwise the result wraps.
module pwl_sequencer #(
  parameter int WI = 8,
  parameter int WF = 8
) (
  input logic            clk,
  input logic            rst_n,
  pwl_sequencer_if.slave bus
);
  localparam int W  = WI + WF;
  localparam int PW = 2 * W + 1;
  localparam int SW = 2 * W + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    MUL    = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        [W-1:0] bound_tbl [16];
  logic signed [W-1:0] slope_tbl [16];
  logic signed [W-1:0] icpt_tbl  [16];

  logic        [W-1:0]  x_p0;
  logic        [3:0]    idx_p0;
  logic        [3:0]    seg_p0;
  logic signed [PW-1:0] prod_p1;
  logic        [W-1:0]  y_p2;
  logic        [3:0]    seg_p2;
  logic                 err_q;

  logic                 accept;
  logic                 hit;
  logic signed [PW-1:0] slope_ext;
  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] shifted;
  logic signed [SW-1:0] sum;

`ifdef PWL_SAT_EN
  function automatic logic [W-1:0] narrow_w(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi = '0;
    hi[W-2:0] = '1;
    lo = '1;
    lo[W-2:0] = '0;
    if (s > hi) begin
      return hi[W-1:0];
    end else if (s < lo) begin
      return lo[W-1:0];
    end
    return s[W-1:0];
  endfunction
`else
  function automatic logic [W-1:0] narrow_w(input logic signed [SW-1:0] s);
    return s[W-1:0];
  endfunction
`endif

  assign accept = bus.in_valid && bus.in_ready;
  assign hit    = (x_p0 <= bound_tbl[idx_p0]) || (idx_p0 == 4'd15);

  // x is unsigned, so it enters the signed product with a zero sign bit.
  assign slope_ext = {{(W + 1){slope_tbl[seg_p0][W-1]}}, slope_tbl[seg_p0]};
  assign x_ext     = {{(W + 1){1'b0}}, x_p0};
  assign shifted   = prod_p1 >>> WF;
  assign sum       = {shifted[PW-1], shifted}
                   + {{(SW - W){icpt_tbl[seg_p0][W-1]}}, icpt_tbl[seg_p0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEARCH;
      SEARCH:  if (hit) state_nxt = MUL;
      MUL:     state_nxt = ADD;
      ADD:     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads low for the whole reset window.
  always_comb begin
    bus.in_ready  = rst_n && (state == IDLE) && !bus.cfg_we;
    bus.busy      = (state != IDLE);
    bus.out_valid = (state == DONE);
    bus.out_y     = y_p2;
    bus.out_seg   = seg_p2;
    bus.cfg_err   = err_q;
  end

  // Tables only change in IDLE, so an accepted transaction always sees a stable table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        bound_tbl[i] <= '1;
        slope_tbl[i] <= '0;
        icpt_tbl[i]  <= '0;
      end
    end else if (bus.cfg_we && (state == IDLE)) begin
      case (bus.cfg_sel)
        2'd0:    bound_tbl[bus.cfg_addr] <= bus.cfg_data;
        2'd1:    slope_tbl[bus.cfg_addr] <= bus.cfg_data;
        2'd2:    icpt_tbl[bus.cfg_addr]  <= bus.cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= bus.cfg_we && ((state != IDLE) || (bus.cfg_sel == 2'd3));
    end
  end

  // Stage p0: accepted argument and segment search
  always_ff @(posedge clk) begin
    if (accept) x_p0 <= bus.in_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_p0 <= '0;
      seg_p0 <= '0;
    end else if (state == IDLE) begin
      if (accept) idx_p0 <= '0;
    end else if (state == SEARCH) begin
      if (hit) seg_p0 <= idx_p0;
      else     idx_p0 <= idx_p0 + 4'd1;
    end
  end

  // Stage p1: product of slope and argument
  always_ff @(posedge clk) begin
    if (state == MUL) prod_p1 <= slope_ext * x_ext;
  end

  // Stage p2: scaled product plus intercept, held until the next ADD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p2   <= '0;
      seg_p2 <= '0;
    end else if (state == ADD) begin
      y_p2   <= narrow_w(sum);
      seg_p2 <= seg_p0;
    end
  end
endmodule
